// File: rtl/alu_issue_if.sv
// Decode-to-EX handshake and operand bundle for the ALU issue stage.
// ALU_ISSUE_FWD_EN adds the forwarding select and result buses.
interface alu_issue_if;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_alu_op;
  logic [5:0]  in_funct;
  logic        in_alu_src;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [31:0] in_imm;
  logic [4:0]  in_rd;
  logic        stall_in;
  logic        flush;
  logic        ex_valid;
  logic [3:0]  ex_op;
  logic [31:0] ex_a;
  logic [31:0] ex_b;
  logic [4:0]  ex_rd;
  logic        busy;
  logic        illegal;
`ifdef ALU_ISSUE_FWD_EN
  logic [1:0]  fwd_a_sel;
  logic [1:0]  fwd_b_sel;
  logic [31:0] exmem_result;
  logic [31:0] memwb_result;
`endif

  modport master (
    output in_valid, in_alu_op, in_funct, in_alu_src, in_a, in_b, in_imm, in_rd,
           stall_in, flush,
`ifdef ALU_ISSUE_FWD_EN
    output fwd_a_sel, fwd_b_sel, exmem_result, memwb_result,
`endif
    input  in_ready, ex_valid, ex_op, ex_a, ex_b, ex_rd, busy, illegal
  );

  modport slave (
    input  in_valid, in_alu_op, in_funct, in_alu_src, in_a, in_b, in_imm, in_rd,
           stall_in, flush,
`ifdef ALU_ISSUE_FWD_EN
    input  fwd_a_sel, fwd_b_sel, exmem_result, memwb_result,
`endif
    output in_ready, ex_valid, ex_op, ex_a, ex_b, ex_rd, busy, illegal
  );
endinterface

// File: rtl/alu_issue_stage.sv
// ID/EX issue stage: ALU op decode, operand B select, EX register, mul/div hold.
// Optional operand forwarding is enabled by defining ALU_ISSUE_FWD_EN.
//
// state | meaning
// IDLE  | accepting instructions; bubbles inserted when nothing is accepted
// HOLD  | mul/div frozen on ex_*; hold_cnt counts remaining cycles down to 0
module alu_issue_stage #(
  parameter int MULDIV_CYCLES = 4
) (
  input logic        clk,
  input logic        rst,
  alu_issue_if.slave bus
);

  localparam int CW = (MULDIV_CYCLES > 1) ? $clog2(MULDIV_CYCLES) : 1;
  localparam logic [CW-1:0] HOLD_LOAD = CW'(MULDIV_CYCLES - 1);
  localparam bit MULDIV_HOLD = (MULDIV_CYCLES > 1);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] hold_cnt, hold_cnt_nxt;
  logic          in_ready, accept, capture;
  logic [3:0]    dec_op;
  logic          dec_illegal;
  logic [31:0]   opnd_a, opnd_b_reg, opnd_b;
  logic          ex_valid, illegal;
  logic [3:0]    ex_op;
  logic [31:0]   ex_a, ex_b;
  logic [4:0]    ex_rd;

  always_comb begin
    dec_op      = 4'd4;
    dec_illegal = 1'b0;
    case (bus.in_alu_op)
      2'b00: dec_op = 4'd2;
      2'b01: dec_op = 4'd6;
      2'b11: dec_op = 4'd1;
      default: begin
        case (bus.in_funct)
          6'h24:   dec_op = 4'd0;
          6'h25:   dec_op = 4'd1;
          6'h20:   dec_op = 4'd2;
          6'h18:   dec_op = 4'd5;
          6'h22:   dec_op = 4'd6;
          6'h2A:   dec_op = 4'd7;
          6'h1A:   dec_op = 4'd8;
          6'h27:   dec_op = 4'd12;
          default: dec_illegal = 1'b1;
        endcase
      end
    endcase
  end

`ifdef ALU_ISSUE_FWD_EN
  always_comb begin
    case (bus.fwd_a_sel)
      2'b01:   opnd_a = bus.exmem_result;
      2'b10:   opnd_a = bus.memwb_result;
      default: opnd_a = bus.in_a;
    endcase
    case (bus.fwd_b_sel)
      2'b01:   opnd_b_reg = bus.exmem_result;
      2'b10:   opnd_b_reg = bus.memwb_result;
      default: opnd_b_reg = bus.in_b;
    endcase
  end
`else
  assign opnd_a     = bus.in_a;
  assign opnd_b_reg = bus.in_b;
`endif

  // Forwarded B is discarded in favour of the immediate when alu_src is set.
  assign opnd_b = bus.in_alu_src ? bus.in_imm : opnd_b_reg;

  always_comb begin
    state_nxt    = state;
    hold_cnt_nxt = hold_cnt;
    capture      = 1'b0;
    in_ready     = (hold_cnt == '0) && !bus.stall_in;
    accept       = bus.in_valid && in_ready;
    if (bus.flush) begin
      state_nxt    = IDLE;
      hold_cnt_nxt = '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            capture = 1'b1;
            if (MULDIV_HOLD && (dec_op == 4'd5 || dec_op == 4'd8)) begin
              state_nxt    = HOLD;
              hold_cnt_nxt = HOLD_LOAD;
            end
          end
        end
        HOLD: begin
          hold_cnt_nxt = hold_cnt - CW'(1);
          if (hold_cnt == CW'(1)) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      hold_cnt <= '0;
      ex_valid <= 1'b0;
      ex_op    <= 4'd4;
      ex_a     <= '0;
      ex_b     <= '0;
      ex_rd    <= '0;
      illegal  <= 1'b0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_cnt_nxt;
      illegal  <= capture && dec_illegal;
      if (capture) begin
        ex_valid <= 1'b1;
        ex_op    <= dec_op;
        ex_a     <= opnd_a;
        ex_b     <= opnd_b;
        ex_rd    <= bus.in_rd;
      end else if (bus.flush || state == IDLE) begin
        ex_valid <= 1'b0;
        ex_op    <= 4'd4;
      end
    end
  end

  assign bus.in_ready = in_ready;
  assign bus.ex_valid = ex_valid;
  assign bus.ex_op    = ex_op;
  assign bus.ex_a     = ex_a;
  assign bus.ex_b     = ex_b;
  assign bus.ex_rd    = ex_rd;
  assign bus.busy     = (state == HOLD);
  assign bus.illegal  = illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed vectors, literal expectations
// and a per-cycle behavioural model of the issue rules.
module tb_alu_issue_stage;
  localparam int MC = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  bit   chk_en = 1'b0;

  alu_issue_if bus ();

  alu_issue_stage #(.MULDIV_CYCLES(MC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks what must be on ex_* and how many more cycles a mul/div stays.
  int          funct_map[64];
  logic        m_valid, m_illegal;
  logic [3:0]  m_op;
  logic [31:0] m_a, m_b;
  logic [4:0]  m_rd;
  int          m_rem;

  initial begin
    for (int i = 0; i < 64; i++) funct_map[i] = -1;
    funct_map[6'h24] = 0;  funct_map[6'h25] = 1;  funct_map[6'h20] = 2;
    funct_map[6'h18] = 5;  funct_map[6'h22] = 6;  funct_map[6'h2A] = 7;
    funct_map[6'h1A] = 8;  funct_map[6'h27] = 12;
  end

  always @(posedge clk) begin
    int          op;
    logic [31:0] a, b;
    if (rst) begin
      m_valid = 0; m_op = 4; m_a = 0; m_b = 0; m_rd = 0; m_illegal = 0; m_rem = 0;
    end else if (bus.flush) begin
      m_valid = 0; m_op = 4; m_illegal = 0; m_rem = 0;
    end else if (m_rem > 0) begin
      m_rem--; m_illegal = 0;
    end else if (bus.in_valid && !bus.stall_in) begin
      m_illegal = 0;
      case (bus.in_alu_op)
        2'b00: op = 2;
        2'b01: op = 6;
        2'b11: op = 1;
        default: begin
          op = funct_map[bus.in_funct];
          if (op < 0) begin op = 4; m_illegal = 1; end
        end
      endcase
      a = bus.in_a;
      b = bus.in_b;
`ifdef ALU_ISSUE_FWD_EN
      if (bus.fwd_a_sel == 2'b01) a = bus.exmem_result;
      else if (bus.fwd_a_sel == 2'b10) a = bus.memwb_result;
      if (bus.fwd_b_sel == 2'b01) b = bus.exmem_result;
      else if (bus.fwd_b_sel == 2'b10) b = bus.memwb_result;
`endif
      if (bus.in_alu_src) b = bus.in_imm;
      m_valid = 1; m_op = 4'(op); m_a = a; m_b = b; m_rd = bus.in_rd;
      m_rem = (op == 5 || op == 8) ? MC - 1 : 0;
    end else begin
      m_valid = 0; m_op = 4; m_illegal = 0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_ex_valid", 32'(bus.ex_valid), 32'(m_valid));
      chk("m_ex_op",    32'(bus.ex_op),    32'(m_op));
      chk("m_ex_a",     bus.ex_a,          m_a);
      chk("m_ex_b",     bus.ex_b,          m_b);
      chk("m_ex_rd",    32'(bus.ex_rd),    32'(m_rd));
      chk("m_busy",     32'(bus.busy),     32'(m_rem > 0));
      chk("m_illegal",  32'(bus.illegal),  32'(m_illegal));
      chk("m_in_ready", 32'(bus.in_ready), 32'((m_rem == 0) && !bus.stall_in));
    end
  end

  task automatic drive(input logic v, input logic [1:0] op, input logic [5:0] f,
                       input logic src, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] imm, input logic [4:0] rd);
    bus.in_valid = v;   bus.in_alu_op = op; bus.in_funct = f; bus.in_alu_src = src;
    bus.in_a = a;       bus.in_b = b;       bus.in_imm = imm; bus.in_rd = rd;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [1:0]  v_op[8]  = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10};
  logic [5:0]  v_fn[8]  = '{6'h00, 6'h00, 6'h00, 6'h24, 6'h25, 6'h20, 6'h2A, 6'h27};
  logic [3:0]  v_exp[8] = '{4'd2,  4'd6,  4'd1,  4'd0,  4'd1,  4'd2,  4'd7,  4'd12};

  initial begin
    bus.stall_in = 0;
    bus.flush    = 0;
`ifdef ALU_ISSUE_FWD_EN
    bus.fwd_a_sel = 0; bus.fwd_b_sel = 0; bus.exmem_result = 0; bus.memwb_result = 0;
`endif
    drive(0, 2'b00, 6'h00, 0, 0, 0, 0, 0);

    step(); step();
    chk_en = 1;
    chk("rst_ex_valid", 32'(bus.ex_valid), 32'd0);
    chk("rst_ex_op",    32'(bus.ex_op),    32'd4);
    chk("rst_ex_a",     bus.ex_a,          32'd0);
    chk("rst_ex_b",     bus.ex_b,          32'd0);
    chk("rst_busy",     32'(bus.busy),     32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    rst = 0;

    drive(1, 2'b10, 6'h22, 0, 32'd9, 32'd4, 32'd0, 5'd3);
    step();
    chk("sub_op",    32'(bus.ex_op),    32'd6);
    chk("sub_a",     bus.ex_a,          32'd9);
    chk("sub_b",     bus.ex_b,          32'd4);
    chk("sub_valid", 32'(bus.ex_valid), 32'd1);

    // mul held MC cycles; a queued add is taken the cycle after the hold ends
    drive(1, 2'b10, 6'h18, 0, 32'd3, 32'd5, 32'd0, 5'd7);
    step();
    drive(1, 2'b00, 6'h00, 0, 32'd1, 32'd2, 32'd0, 5'd8);
    #1;
    for (int i = 0; i < MC; i++) begin
      chk("mul_hold_op", 32'(bus.ex_op),    32'd5);
      chk("mul_ready",   32'(bus.in_ready), 32'(i == MC - 1));
      chk("mul_busy",    32'(bus.busy),     32'(i < MC - 1));
      step();
    end
    chk("after_mul_op", 32'(bus.ex_op), 32'd2);
    chk("after_mul_a",  bus.ex_a,       32'd1);
    drive(0, 2'b00, 6'h00, 0, 0, 0, 0, 0);
    step();

    // flush in the 2nd hold cycle of a div with in_valid high
    drive(1, 2'b10, 6'h1A, 0, 32'd20, 32'd3, 32'd0, 5'd9);
    step();
    drive(1, 2'b11, 6'h00, 1, 32'd5, 32'd6, 32'hF0, 5'd10);
    step();
    bus.flush = 1;
    step();
    chk("flush_valid", 32'(bus.ex_valid), 32'd0);
    chk("flush_op",    32'(bus.ex_op),    32'd4);
    chk("flush_busy",  32'(bus.busy),     32'd0);
    chk("flush_rd",    32'(bus.ex_rd),    32'd9);
    bus.flush = 0;
    step();
    chk("ori_op", 32'(bus.ex_op), 32'd1);
    chk("ori_b",  bus.ex_b,       32'hF0);

    drive(1, 2'b10, 6'h3F, 0, 32'd1, 32'd1, 32'd0, 5'd2);
    step();
    chk("ill_op",    32'(bus.ex_op),   32'd4);
    chk("ill_flag",  32'(bus.illegal), 32'd1);
    drive(1, 2'b00, 6'h00, 0, 32'd4, 32'd4, 32'd0, 5'd4);
    bus.stall_in = 1;
    #1;
    chk("stall_ready", 32'(bus.in_ready), 32'd0);
    step();
    chk("stall_valid", 32'(bus.ex_valid), 32'd0);
    chk("ill_clear",   32'(bus.illegal),  32'd0);
    bus.stall_in = 0;

    // stall during hold has no extra effect
    drive(1, 2'b10, 6'h18, 0, 32'd6, 32'd7, 32'd0, 5'd11);
    step();
    drive(0, 2'b00, 6'h00, 0, 0, 0, 0, 0);
    bus.stall_in = 1;
    for (int i = 0; i < MC - 1; i++) step();
    chk("stallhold_busy", 32'(bus.busy),  32'd0);
    chk("stallhold_op",   32'(bus.ex_op), 32'd5);
    bus.stall_in = 0;
    step();
    chk("stallhold_bubble", 32'(bus.ex_op), 32'd4);

    // reset in the middle of a hold
    drive(1, 2'b10, 6'h1A, 0, 32'd8, 32'd2, 32'd0, 5'd12);
    step();
    drive(0, 2'b00, 6'h00, 0, 0, 0, 0, 0);
    rst = 1;
    bus.flush = 1;
    step();
    chk("rsthold_busy", 32'(bus.busy), 32'd0);
    chk("rsthold_a",    bus.ex_a,      32'd0);
    rst = 0;
    bus.flush = 0;
    step();

    for (int i = 0; i < 8; i++) begin
      drive(1, v_op[i], v_fn[i], v_op[i] == 2'b11, 32'(i * 3 + 1), 32'(i + 40),
            32'h100 + 32'(i), 5'(i + 16));
      step();
      chk("dec_op", 32'(bus.ex_op), 32'(v_exp[i]));
    end
    drive(0, 2'b00, 6'h00, 0, 0, 0, 0, 0);
    step();

`ifdef ALU_ISSUE_FWD_EN
    bus.fwd_a_sel = 2'b01; bus.exmem_result = 32'h55;
    drive(1, 2'b00, 6'h00, 0, 32'h11, 32'h22, 32'd0, 5'd1);
    step();
    chk("fwd_a", bus.ex_a, 32'h55);
    bus.fwd_a_sel = 2'b00; bus.fwd_b_sel = 2'b10; bus.memwb_result = 32'h99;
    drive(1, 2'b11, 6'h00, 1, 32'h11, 32'h22, 32'd7, 5'd1);
    step();
    chk("fwd_b_imm", bus.ex_b, 32'd7);
    drive(1, 2'b00, 6'h00, 0, 32'h11, 32'h22, 32'd7, 5'd1);
    step();
    chk("fwd_b_reg", bus.ex_b, 32'h99);
    bus.fwd_b_sel = 2'b00;
    drive(0, 2'b00, 6'h00, 0, 0, 0, 0, 0);
    step();
`endif

    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
